burst_rd_fsm: RTL and testbench
===============================

BURST_RD_FSM -- requirements
Module: burst_rd_fsm

Interface
REQ-001 Parameter BURST_LEN, default 4: read beats per burst, legal range 1..2**CNT_W.
REQ-002 Parameter CNT_W, default 4: width of the beat counter.
REQ-003 Parameter WS_MAX, default 8: consecutive wait-state cycles that trigger a timeout, legal range 1..255; used only with the timeout feature.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 go  input  1  burst request, sampled only in IDLE.
REQ-007 ws  input  1  wait-state request from memory; while high, the current beat is not accepted.
REQ-008 rd  output  1  read strobe, high in READ and WAIT.
REQ-009 ds  output  1  done strobe, high for the single DONE cycle.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 beat_cnt  output  CNT_W  index of the beat currently presented.
REQ-012 err  output  1  timeout strobe, high for the single ERR cycle.

Function
REQ-013 States: IDLE, READ, WAIT, DONE, ERR, held in a state register.
REQ-014 rd, ds, busy and err shall decode from the state register only, with no combinational path from any input to any output.
REQ-015 IDLE: go=1 -> READ with beat_cnt<=0; go=0 -> stay in IDLE.
REQ-016 READ or WAIT with ws=0: the beat is accepted; if beat_cnt==BURST_LEN-1 -> DONE, else increment beat_cnt and go to READ.
REQ-017 READ or WAIT with ws=1: go to WAIT, and beat_cnt holds.
REQ-018 DONE -> IDLE unconditionally, and go in DONE is ignored.
REQ-019 ERR -> IDLE unconditionally, with beat_cnt<=0.
REQ-020 Latency: go sampled at edge N gives rd high from cycle N+1; with ws=0 throughout, rd is high for exactly BURST_LEN cycles and ds is high in cycle N+1+BURST_LEN.
REQ-021 Each cycle of ws=1 in READ or WAIT extends the burst by exactly one cycle.
REQ-022 go held high continuously shall start a new burst on every IDLE cycle, so bursts are separated by one DONE cycle and one IDLE cycle.
REQ-023 BURST_LEN=1: a burst is one READ cycle, then DONE.
REQ-024 beat_cnt shall never exceed BURST_LEN-1 and shall never wrap.
REQ-025 In IDLE, beat_cnt shall hold its last value.

Reset
REQ-026 rst_n=0 at a rising edge shall force IDLE, beat_cnt=0 and the wait counter=0, in any state, including mid-burst.
REQ-027 While in reset and on the cycle after reset: rd=0, ds=0, busy=0, err=0; no ds or err pulse is generated by an aborted burst.
REQ-028 Reset shall take priority over go, ws and the timeout.

Configuration
REQ-029 Macro FSM_TIMEOUT_EN, when defined: an 8-bit wait counter clears on every entry to WAIT from READ, increments each cycle in WAIT with ws=1, and clears on leaving WAIT.
REQ-030 With FSM_TIMEOUT_EN: when the counter reaches WS_MAX-1 while ws=1 in WAIT, the next state is ERR, so the FSM spends WS_MAX cycles in WAIT before ERR.
REQ-031 With FSM_TIMEOUT_EN: entering ERR produces one err cycle and no ds.
REQ-032 Without FSM_TIMEOUT_EN: the wait counter and ERR state are not implemented, err is tied to 0, and WAIT persists indefinitely while ws=1.

Verification
REQ-033 rst_n=0 for 2 cycles from any state -> rd=ds=busy=err=0, beat_cnt=0.
REQ-034 BURST_LEN=4, one-cycle go pulse, ws=0 -> rd high 4 cycles with beat_cnt 0,1,2,3, then ds high 1 cycle, then IDLE.
REQ-035 BURST_LEN=4, ws=1 for 2 cycles while beat_cnt=1 -> rd high 6 cycles, beat_cnt stays 1 during WAIT, single ds.
REQ-036 FSM_TIMEOUT_EN with WS_MAX=8, ws held high -> WAIT for 8 cycles, err high 1 cycle, no ds, IDLE next; without the macro, ws high for 20 cycles then low -> burst completes with ds and err=0.
REQ-037 rst_n=0 at beat_cnt=2 mid-burst -> IDLE at that edge, busy=0, no ds; a go afterwards restarts at beat_cnt=0.
REQ-038 go held high, BURST_LEN=2 -> repeating pattern READ, READ, DONE, IDLE, with ds every 4 cycles.

Source files
------------

// File: rtl/burst_rd_fsm.sv
// burst_rd_fsm -- burst read sequencer.
//
// Issues BURST_LEN read beats per burst request. The memory may stall any
// beat with ws; a stalled beat is re-presented (beat_cnt holds) until accepted.
//
// Parameters:
//   BURST_LEN  beats per burst, 1..2**CNT_W
//   CNT_W      width of beat_cnt
//   WS_MAX     consecutive stalled WAIT cycles before a timeout, 1..255
//              (only meaningful when FSM_TIMEOUT_EN is defined)
//
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   go        burst request, sampled in IDLE only
//   ws        wait-state request; current beat not accepted while high
//   rd        read strobe, high in READ and WAIT
//   ds        done strobe, one cycle at end of a completed burst
//   busy      high in every state except IDLE
//   beat_cnt  index of the beat currently presented
//   err       timeout strobe, one cycle (always 0 without FSM_TIMEOUT_EN)
//
// Build option:
//   FSM_TIMEOUT_EN  adds an 8-bit wait counter and the ERR state.
module burst_rd_fsm #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4,
  parameter int WS_MAX    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             ws,
  output logic             rd,
  output logic             ds,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             err
);

  if (BURST_LEN < 1 || BURST_LEN > 2**CNT_W || WS_MAX < 1 || WS_MAX > 255) begin : g_bad_params
    $error("burst_rd_fsm: illegal parameter combination");
  end

`ifdef FSM_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, READ, WAIT, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, WAIT, DONE} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;

`ifdef FSM_TIMEOUT_EN
  localparam logic [7:0] WS_LAST = 8'(WS_MAX - 1);
  logic [7:0] wcnt, wcnt_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
`ifdef FSM_TIMEOUT_EN
      wcnt     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
`ifdef FSM_TIMEOUT_EN
      wcnt     <= wcnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
`ifdef FSM_TIMEOUT_EN
    wcnt_nxt  = wcnt;
`endif
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = READ;
          cnt_nxt   = '0;
        end
      end
      READ, WAIT: begin
        if (!ws) begin
`ifdef FSM_TIMEOUT_EN
          wcnt_nxt = '0;
`endif
          if (beat_cnt == LAST_BEAT) begin
            state_nxt = DONE;
          end else begin
            state_nxt = READ;
            cnt_nxt   = beat_cnt + CNT_W'(1);
          end
        end else if (state == READ) begin
          state_nxt = WAIT;
`ifdef FSM_TIMEOUT_EN
          wcnt_nxt  = '0;
`endif
        end else begin
`ifdef FSM_TIMEOUT_EN
          // Counter values 0..WS_MAX-1 each cost one WAIT cycle, so the
          // timeout fires after exactly WS_MAX stalled WAIT cycles.
          if (wcnt == WS_LAST) begin
            state_nxt = ERR;
            wcnt_nxt  = '0;
          end else begin
            wcnt_nxt  = wcnt + 8'd1;
          end
`else
          state_nxt = WAIT;
`endif
        end
      end
      DONE: state_nxt = IDLE;
`ifdef FSM_TIMEOUT_EN
      ERR: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // All strobes decode from the state register only.
  assign rd   = (state == READ) || (state == WAIT);
  assign ds   = (state == DONE);
  assign busy = (state != IDLE);
`ifdef FSM_TIMEOUT_EN
  assign err  = (state == ERR);
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_burst_rd_fsm.sv
module tb_burst_rd_fsm;

  localparam int BL  = 4;
  localparam int CW  = 4;
  localparam int WSM = 8;

  localparam int S_IDLE = 0;
  localparam int S_READ = 1;
  localparam int S_WAIT = 2;
  localparam int S_DONE = 3;
  localparam int S_ERR  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          ws = 1'b0;
  logic          rd, ds, busy, err;
  logic [CW-1:0] beat_cnt;

  always #5 clk = ~clk;

  burst_rd_fsm #(.BURST_LEN(BL), .CNT_W(CW), .WS_MAX(WSM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .ws       (ws),
    .rd       (rd),
    .ds       (ds),
    .busy     (busy),
    .beat_cnt (beat_cnt),
    .err      (err)
  );

  typedef struct packed {
    logic          rd;
    logic          ds;
    logic          busy;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_st  = S_IDLE;
  int m_cnt = 0;
  int m_wc  = 0;

  // observation counters for directed checks
  int cyc = 0;
  int rd_seen = 0, ds_seen = 0, err_seen = 0, last_ds = -1;
  bit track_period = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic r, input logic g, input logic w);
    if (!r) begin
      m_st = S_IDLE; m_cnt = 0; m_wc = 0;
    end else begin
      case (m_st)
        S_IDLE: if (g) begin m_st = S_READ; m_cnt = 0; end
        S_READ, S_WAIT: begin
          if (!w) begin
            m_wc = 0;
            if (m_cnt == BL - 1) m_st = S_DONE;
            else begin m_cnt = m_cnt + 1; m_st = S_READ; end
          end else if (m_st == S_READ) begin
            m_st = S_WAIT; m_wc = 0;
          end else begin
`ifdef FSM_TIMEOUT_EN
            if (m_wc == WSM - 1) begin m_st = S_ERR; m_wc = 0; end
            else m_wc = m_wc + 1;
`endif
          end
        end
        S_DONE: m_st = S_IDLE;
        default: begin m_st = S_IDLE; m_cnt = 0; end
      endcase
    end
  endtask

  task automatic step(input logic r, input logic g, input logic w);
    exp_t e;
    rst_n = r; go = g; ws = w;
    @(posedge clk);
    model_edge(r, g, w);
    e.rd   = (m_st == S_READ) || (m_st == S_WAIT);
    e.ds   = (m_st == S_DONE);
    e.busy = (m_st != S_IDLE);
    e.err  = (m_st == S_ERR);
    e.cnt  = CW'(m_cnt);
    q.push_back(e);
    #1;
    cyc++;
    if (q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check("rd",       {31'd0, rd},   {31'd0, e.rd});
      check("ds",       {31'd0, ds},   {31'd0, e.ds});
      check("busy",     {31'd0, busy}, {31'd0, e.busy});
      check("err",      {31'd0, err},  {31'd0, e.err});
      check("beat_cnt", 32'(beat_cnt), 32'(e.cnt));
    end
    if (rd === 1'b1)  rd_seen++;
    if (err === 1'b1) err_seen++;
    if (ds === 1'b1) begin
      ds_seen++;
      if (track_period && last_ds >= 0) check("ds_period", 32'(cyc - last_ds), 32'(BL + 2));
      last_ds = cyc;
    end
  endtask

  task automatic clr_obs();
    rd_seen = 0; ds_seen = 0; err_seen = 0; last_ds = -1;
  endtask

  initial begin
    // reset for two cycles
    step(0, 0, 0);
    step(0, 1, 1);
    check("rst_cnt_direct", 32'(beat_cnt), 32'd0);

    // plain burst, ws low
    clr_obs();
    step(1, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    check("plain_rd_cycles", 32'(rd_seen), 32'(BL));
    check("plain_ds_count",  32'(ds_seen), 32'd1);
    check("plain_ds_cycle",  32'(last_ds), 32'(cyc - 7 + BL));

    // two stall cycles while beat 1 is presented
    clr_obs();
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    check("stall_rd_cycles", 32'(rd_seen), 32'(BL + 2));
    check("stall_ds_count",  32'(ds_seen), 32'd1);

    // long stall: 20 cycles of ws
    clr_obs();
    step(1, 1, 0);
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
`ifdef FSM_TIMEOUT_EN
    check("long_err_count", 32'(err_seen), 32'd1);
    check("long_ds_count",  32'(ds_seen), 32'd0);
`else
    check("long_err_count", 32'(err_seen), 32'd0);
    check("long_ds_count",  32'(ds_seen), 32'd1);
`endif

    // reset mid-burst at beat 2, then restart
    clr_obs();
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("mid_cnt_before", 32'(beat_cnt), 32'd2);
    step(0, 1, 0);
    check("mid_busy_after_rst", {31'd0, busy}, 32'd0);
    step(1, 1, 0);
    check("mid_restart_cnt", 32'(beat_cnt), 32'd0);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    check("mid_ds_count", 32'(ds_seen), 32'd1);

    // go held high: back-to-back bursts
    clr_obs();
    track_period = 1'b1;
    for (int i = 0; i < 4 * (BL + 2); i++) step(1, 1, 0);
    track_period = 1'b0;
    check("held_ds_count", 32'(ds_seen), 32'd4);

    // random traffic with occasional reset
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));

    // final reset from whatever state
    step(0, 1, 1);
    step(0, 1, 1);
    check("final_rst_cnt", 32'(beat_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
